pv_peak_sweep: RTL and testbench
================================

Name: pv_peak_sweep

Overview:
Sweep controller that drives the tracker servo across its range, requests one ADC conversion per position, and writes each new maximum into the external max-voltage register via its PV/GT store interface. It reads back the stored value on LV and compares each fresh sample against it. After the sweep it parks the servo at the position of the highest sample. It sits between the ADC front-end, the max-voltage register and the servo PWM stage.

Parameters:
DATA_W, 12, ADC sample and stored-value width
POS_W, 8, servo position width
POS_MIN, 0, first sweep position
POS_MAX, 180, last sweep position (POS_MAX >= POS_MIN)
STEP, 1, position increment per step (>= 1)
SETTLE_CYC, 1000, cycles waited after each move before sampling (>= 1)
ADC_TIMEOUT, 4096, cycles allowed for ADC_VALID after ADC_REQ

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
START  in  1  begin sweep (level sampled in IDLE only)
ADC_REQ  out  1  one-cycle conversion request
ADC_VALID  in  1  sample valid strobe
ADC_DATA  in  DATA_W  sample
GT  out  1  one-cycle store strobe to max register
PV  out  DATA_W  value to store, valid while GT=1
LV  in  DATA_W  currently stored max, updated the cycle after GT
POS  out  POS_W  servo position command
BEST_POS  out  POS_W  position of the largest sample in the last sweep
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at sweep end
ERR  out  1  sticky: at least one ADC timeout this sweep; cleared on accepted START

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. RST has priority over all other inputs.
- Reset values: state IDLE, POS=POS_MIN, BEST_POS=POS_MIN, GT=0, PV=0, ADC_REQ=0, BUSY=0, DONE=0, ERR=0, all counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE: START=1 -> CLEAR; ERR<=0.
  - CLEAR (1 cycle): GT=1, PV=0, POS<=POS_MIN, BEST_POS<=POS_MIN, settle counter<=SETTLE_CYC-1 -> SETTLE.
  - SETTLE: decrement counter; when counter=0 -> REQ.
  - REQ (1 cycle): ADC_REQ=1, timeout counter<=ADC_TIMEOUT-1 -> WAIT_ADC.
  - WAIT_ADC: ADC_VALID=1 -> capture ADC_DATA, go to COMPARE. Timeout counter=0 with no valid -> ERR<=1, captured sample<=0, go to COMPARE.
  - COMPARE (1 cycle):
    - If sample > LV (strict, unsigned): GT=1, PV=sample, BEST_POS<=POS.
    - If POS=POS_MAX -> RETURN.
    - Otherwise POS<=min(POS+STEP, POS_MAX), with the sum computed in POS_W+1 bits, and reload the settle counter -> SETTLE.
  - RETURN (1 cycle): POS<=BEST_POS, DONE=1 -> IDLE.
- Ties keep the earliest (lowest) position.
- An all-zero sweep leaves BEST_POS=POS_MIN.
- POS_MAX is always measured, even when the range is not a multiple of STEP.
- Per-position latency = SETTLE_CYC + 1 + ADC latency + 1 cycles.
- LV is always at least 2 cycles old when used, so the register's one-cycle update latency is safe.
- Ignored inputs:
  - START while BUSY=1.
  - ADC_VALID outside WAIT_ADC, including a late valid arriving after a timeout.
- GT is never high for more than 1 consecutive cycle.
- RST mid-sweep returns to reset values on the next edge. No DONE is issued, and the external register is left as-is.

Decomposition:
- Shared package:
  - state enum (IDLE, CLEAR, SETTLE, REQ, WAIT_ADC, COMPARE, RETURN).
  - DATA_W/POS_W defaults.
  - Servo range constants POS_MIN/POS_MAX.
- One sub-module, pv_cycle_timer: loadable down-counter with zero flag and synchronous reset. Instantiated twice, for settle and ADC timeout.

Test Plan:
Bench setup: model the max register as "LV<=PV on posedge when GT". Parameters POS_MIN=0, POS_MAX=4, STEP=1, SETTLE_CYC=2, ADC_TIMEOUT=8, ADC responds 3 cycles after ADC_REQ.
- RST=1 for 2 cycles -> POS=0, BEST_POS=0, GT=0, ADC_REQ=0, BUSY=0, DONE=0, ERR=0.
- START; samples 100,300,200,300,50 at POS 0..4 -> GT pulses: CLEAR (PV=0), pos0 (PV=100), pos1 (PV=300), none after. BEST_POS=1, final POS=1, exactly one DONE, LV=300. Each position's ADC_REQ comes 2 cycles after its POS change.
- All samples 0 -> only the CLEAR GT pulse; BEST_POS=0, POS=0 after DONE.
- STEP=3 -> positions visited 0,3,4 only; samples 10,20,30 -> BEST_POS=4.
- No ADC_VALID at pos2 -> ERR=1 after 8 cycles, sweep continues. Pos2 is never BEST_POS. A valid pulsed 2 cycles later is ignored. Next START clears ERR.
- START held high throughout -> no restart until IDLE. RST during WAIT_ADC at pos3 -> reset values next cycle, no DONE, a later ADC_VALID is ignored.

Source files
------------

// File: rtl/pv_peak_sweep_pkg.sv
// Shared types and defaults for the PV peak sweep controller.
// Holds the sweep state encoding, default widths and servo range.
package pv_peak_sweep_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int POS_W_DEF   = 8;
  localparam int POS_MIN_DEF = 0;
  localparam int POS_MAX_DEF = 180;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    REQ,
    WAIT_ADC,
    COMPARE,
    RETURN
  } state_t;

endpackage

// File: rtl/pv_cycle_timer.sv
// Loadable down-counter with zero flag and synchronous reset.
// Ports: clk, rst, load/load_val (load wins), en (count down), zero.
module pv_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pv_peak_sweep.sv
// Servo sweep controller: samples the ADC at each position, stores new
// maxima via GT/PV, reads the stored max on LV, then parks at the best.
// Ports: CLK/RST, START, ADC_REQ/ADC_VALID/ADC_DATA, GT/PV/LV,
// POS/BEST_POS servo commands, BUSY/DONE/ERR status.
module pv_peak_sweep
  import pv_peak_sweep_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int POS_W       = POS_W_DEF,
  parameter int POS_MIN     = POS_MIN_DEF,
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int STEP        = 1,
  parameter int SETTLE_CYC  = 1000,
  parameter int ADC_TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              ADC_REQ,
  input  logic              ADC_VALID,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              GT,
  output logic [DATA_W-1:0] PV,
  input  logic [DATA_W-1:0] LV,
  output logic [POS_W-1:0]  POS,
  output logic [POS_W-1:0]  BEST_POS,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int TW  = $clog2(ADC_TIMEOUT + 1);
  localparam int PW1 = POS_W + 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LOAD    = TW'(ADC_TIMEOUT - 1);

  localparam logic [POS_W-1:0] P_MIN = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [PW1-1:0]   P_MAX_X = PW1'(POS_MAX);
  localparam logic [PW1-1:0]   STEP_X  = PW1'(STEP);

  state_t            state;
  logic [DATA_W-1:0] sample;
  logic              settle_load;
  logic              settle_zero;
  logic              tmo_load;
  logic              tmo_zero;
  logic [PW1-1:0]    pos_sum;
  logic [POS_W-1:0]  pos_next;

  assign settle_load = (state == CLEAR) ||
                       ((state == COMPARE) && (POS != P_MAX));
  assign tmo_load    = (state == REQ);

  // Extra bit keeps the step from wrapping past the top of the range,
  // so the last position is clamped to POS_MAX and always measured.
  assign pos_sum  = {1'b0, POS} + STEP_X;
  assign pos_next = (pos_sum > P_MAX_X) ? P_MAX : pos_sum[POS_W-1:0];

  pv_cycle_timer #(
    .W (SW)
  ) u_settle (
    .clk      (CLK),
    .rst      (RST),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (state == SETTLE),
    .zero     (settle_zero)
  );

  pv_cycle_timer #(
    .W (TW)
  ) u_timeout (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .en       (state == WAIT_ADC),
    .zero     (tmo_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      POS      <= P_MIN;
      BEST_POS <= P_MIN;
      GT       <= 1'b0;
      PV       <= '0;
      ADC_REQ  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      sample   <= '0;
    end else begin
      GT      <= 1'b0;
      ADC_REQ <= 1'b0;
      DONE    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            // GT rises with CLEAR so the stored max is zeroed first.
            ERR   <= 1'b0;
            GT    <= 1'b1;
            PV    <= '0;
            BUSY  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          POS      <= P_MIN;
          BEST_POS <= P_MIN;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (settle_zero) begin
            ADC_REQ <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          state <= WAIT_ADC;
        end
        WAIT_ADC: begin
          if (ADC_VALID) begin
            sample <= ADC_DATA;
            state  <= COMPARE;
          end else if (tmo_zero) begin
            ERR    <= 1'b1;
            sample <= '0;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          // Strict compare: a tie keeps the earlier position.
          if (sample > LV) begin
            GT       <= 1'b1;
            PV       <= sample;
            BEST_POS <= POS;
          end
          if (POS == P_MAX) begin
            state <= RETURN;
          end else begin
            POS   <= pos_next;
            state <= SETTLE;
          end
        end
        RETURN: begin
          POS   <= BEST_POS;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pv_peak_sweep.sv
// Directed bench for pv_peak_sweep with a modelled max register
// and ADC responders for a STEP=1 and a STEP=3 instance.
module tb_pv_peak_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: range 0..4, STEP 1
  logic        start_a = 1'b0;
  logic        valid_a = 1'b0;
  logic [11:0] data_a  = '0;
  logic [11:0] lv_a    = '0;
  logic        req_a;
  logic        gt_a;
  logic [11:0] pv_a;
  logic [7:0]  pos_a;
  logic [7:0]  best_a;
  logic        busy_a;
  logic        done_a;
  logic        err_a;

  // DUT B: range 0..4, STEP 3
  logic        start_b = 1'b0;
  logic        valid_b = 1'b0;
  logic [11:0] data_b  = '0;
  logic [11:0] lv_b    = '0;
  logic        req_b;
  logic        gt_b;
  logic [11:0] pv_b;
  logic [7:0]  pos_b;
  logic [7:0]  best_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;

  pv_peak_sweep #(
    .DATA_W(12), .POS_W(8), .POS_MIN(0), .POS_MAX(4),
    .STEP(1), .SETTLE_CYC(2), .ADC_TIMEOUT(8)
  ) dut_a (
    .CLK(clk), .RST(rst), .START(start_a),
    .ADC_REQ(req_a), .ADC_VALID(valid_a), .ADC_DATA(data_a),
    .GT(gt_a), .PV(pv_a), .LV(lv_a),
    .POS(pos_a), .BEST_POS(best_a),
    .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
  );

  pv_peak_sweep #(
    .DATA_W(12), .POS_W(8), .POS_MIN(0), .POS_MAX(4),
    .STEP(3), .SETTLE_CYC(2), .ADC_TIMEOUT(8)
  ) dut_b (
    .CLK(clk), .RST(rst), .START(start_b),
    .ADC_REQ(req_b), .ADC_VALID(valid_b), .ADC_DATA(data_b),
    .GT(gt_b), .PV(pv_b), .LV(lv_b),
    .POS(pos_b), .BEST_POS(best_b),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
  );

  // External max registers
  always @(posedge clk) if (gt_a) lv_a <= pv_a;
  always @(posedge clk) if (gt_b) lv_b <= pv_b;

  // ADC responder A: valid 3 cycles after ADC_REQ; a dropped
  // position instead gets a late valid 2 cycles after the timeout.
  logic [11:0] samp_a [5];
  int          drop_a = -1;
  int          cnt_a  = 0;
  int          rpos_a = 0;
  logic        late_a = 1'b0;

  always @(negedge clk) begin
    valid_a = 1'b0;
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 1) begin
        valid_a = 1'b1;
        data_a  = late_a ? 12'd4000 : samp_a[rpos_a];
      end
    end
    if (req_a) begin
      rpos_a = int'(pos_a);
      late_a = (rpos_a == drop_a);
      cnt_a  = late_a ? 11 : 3;
    end
  end

  logic [11:0] samp_b [5];
  int          cnt_b  = 0;
  int          rpos_b = 0;
  int          reqpos_b [$];

  always @(negedge clk) begin
    valid_b = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 1) begin
        valid_b = 1'b1;
        data_b  = samp_b[rpos_b];
      end
    end
    if (req_b) begin
      rpos_b = int'(pos_b);
      reqpos_b.push_back(rpos_b);
      cnt_b = 3;
    end
  end

  // Monitors on DUT A
  logic [11:0] gt_log_a [$];
  int          done_cnt_a = 0;
  int          gt_consec  = 0;
  logic        gt_prev    = 1'b0;
  int          cyc        = 0;
  int          chg_cyc    = -100;
  int          req_cyc    = -100;
  logic [7:0]  pos_prev   = '0;
  int          gap_chk    = 0;
  int          gap_bad    = 0;

  always @(negedge clk) begin
    cyc++;
    if (gt_a) gt_log_a.push_back(pv_a);
    if (gt_a && gt_prev) gt_consec++;
    gt_prev = gt_a;
    if (done_a) done_cnt_a++;
    if (pos_a != pos_prev) chg_cyc = cyc;
    pos_prev = pos_a;
    if (req_a) begin
      if (chg_cyc > req_cyc) begin
        gap_chk++;
        if (cyc - chg_cyc != 2) gap_bad++;
      end
      req_cyc = cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < 400);
    check(tag, done_a, 1);
  endtask

  task automatic wait_done_b(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_b && n < 400);
    check(tag, done_b, 1);
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  int snap_chk;
  int snap_bad;
  int snap_done;
  int n;

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_pos", pos_a, 0);
    check("rst_best", best_a, 0);
    check("rst_gt", gt_a, 0);
    check("rst_pv", pv_a, 0);
    check("rst_req", req_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    rst = 1'b0;

    // Sweep 1: 100,300,200,300,50
    samp_a[0] = 100; samp_a[1] = 300; samp_a[2] = 200;
    samp_a[3] = 300; samp_a[4] = 50;
    gt_log_a.delete();
    pulse_start_a();
    check("s1_busy", busy_a, 1);
    wait_done_a("s1_done_seen");
    check("s1_pos", pos_a, 1);
    check("s1_best", best_a, 1);
    check("s1_busy_end", busy_a, 0);
    check("s1_err", err_a, 0);
    snap_chk = gap_chk;
    snap_bad = gap_bad;
    @(negedge clk);
    check("s1_done_cnt", done_cnt_a, 1);
    check("s1_gt_cnt", gt_log_a.size(), 3);
    check("s1_gt0", gt_log_a[0], 0);
    check("s1_gt1", gt_log_a[1], 100);
    check("s1_gt2", gt_log_a[2], 300);
    check("s1_lv", lv_a, 300);
    check("s1_gap_chk", snap_chk, 4);
    check("s1_gap_bad", snap_bad, 0);

    // Sweep 2: all zero
    for (int i = 0; i < 5; i++) samp_a[i] = 0;
    gt_log_a.delete();
    pulse_start_a();
    wait_done_a("s2_done_seen");
    check("s2_pos", pos_a, 0);
    check("s2_best", best_a, 0);
    @(negedge clk);
    check("s2_gt_cnt", gt_log_a.size(), 1);
    check("s2_gt0", gt_log_a[0], 0);
    check("s2_lv", lv_a, 0);

    // STEP=3 instance: positions 0,3,4
    samp_b[0] = 10; samp_b[1] = 99; samp_b[2] = 99;
    samp_b[3] = 20; samp_b[4] = 30;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b("b_done_seen");
    check("b_best", best_b, 4);
    check("b_pos", pos_b, 4);
    check("b_req_cnt", reqpos_b.size(), 3);
    check("b_req0", reqpos_b[0], 0);
    check("b_req1", reqpos_b[1], 3);
    check("b_req2", reqpos_b[2], 4);
    check("b_lv", lv_b, 30);

    // Sweep 3: ADC silent at pos 2, late valid after timeout
    samp_a[0] = 100; samp_a[1] = 200; samp_a[2] = 0;
    samp_a[3] = 150; samp_a[4] = 50;
    drop_a = 2;
    gt_log_a.delete();
    pulse_start_a();
    wait_done_a("s3_done_seen");
    check("s3_err", err_a, 1);
    check("s3_best", best_a, 1);
    check("s3_pos", pos_a, 1);
    @(negedge clk);
    check("s3_gt_cnt", gt_log_a.size(), 3);
    check("s3_lv", lv_a, 200);

    // Sweep 4: START held; reset during WAIT_ADC at pos 3
    drop_a = -1;
    samp_a[0] = 5; samp_a[1] = 6; samp_a[2] = 7;
    samp_a[3] = 8; samp_a[4] = 9;
    gt_log_a.delete();
    snap_done = done_cnt_a;
    start_a = 1'b1;
    @(negedge clk);
    check("s4_busy", busy_a, 1);
    check("s4_err_clr", err_a, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_a && pos_a == 8'd3) && n < 200);
    check("s4_req_pos3", req_a && pos_a == 8'd3, 1);
    check("s4_gt_cnt", gt_log_a.size(), 4);
    check("s4_gt3", gt_log_a[3], 7);
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b0;
    @(negedge clk);
    check("r_pos", pos_a, 0);
    check("r_best", best_a, 0);
    check("r_busy", busy_a, 0);
    check("r_gt", gt_a, 0);
    check("r_req", req_a, 0);
    check("r_err", err_a, 0);
    check("r_done", done_a, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("r_idle_busy", busy_a, 0);
    check("r_idle_pos", pos_a, 0);
    check("r_no_done", done_cnt_a, snap_done);
    check("r_lv_kept", lv_a, 7);
    check("gt_never_consec", gt_consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
